// File: rtl/point_pkg.sv
// Shared types and sizing for the multi-point finder controller.
package point_pkg;

  localparam int W        = 16;
  localparam int SUM_W    = 22;
  localparam int CNT_W    = 7;
  localparam int MAX_RUNS = 64;
  localparam int PTR_W    = $clog2(MAX_RUNS);
  localparam int MAX_PTS  = 4;
  localparam int MERGE_DH = 2;
  localparam int MERGE_DV = 2;

  typedef enum logic [1:0] {IDLE, MERGE, DIVIDE, PUBLISH} state_e;

  typedef struct packed {
    logic [W-1:0] h;
    logic [W-1:0] v;
  } run_t;

endpackage

// File: rtl/serial_divider.sv
// Restoring serial divider: one load cycle, then one quotient bit per cycle.
module serial_divider
  import point_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SUM_W-1:0] dividend,
  input  logic [CNT_W-1:0] divisor,
  output logic             done,
  output logic [SUM_W-1:0] quotient
);

  logic [CNT_W-1:0] rem;
  logic [CNT_W-1:0] dvs;
  logic [4:0]       steps;
  logic             busy;
  logic [CNT_W:0]   rem_sh;
  logic [CNT_W:0]   diff;

  // The dividend is shifted out of the quotient register as quotient bits shift in.
  always_comb begin
    rem_sh = {rem, quotient[SUM_W-1]};
    diff   = rem_sh - {1'b0, dvs};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem      <= '0;
      dvs      <= '0;
      steps    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      quotient <= '0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        rem      <= '0;
        dvs      <= divisor;
        quotient <= dividend;
        steps    <= 5'(SUM_W);
        busy     <= 1'b1;
      end else if (busy) begin
        if (rem_sh >= {1'b0, dvs}) begin
          rem      <= CNT_W'(diff);
          quotient <= {quotient[SUM_W-2:0], 1'b1};
        end else begin
          rem      <= CNT_W'(rem_sh);
          quotient <= {quotient[SUM_W-2:0], 1'b0};
        end
        steps <= steps - 5'd1;
        if (steps == 5'd1) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/point_merge_sched.sv
// Frame controller: captures pixel runs, merges them into point slots,
// divides the slot sums into centroids and publishes them once per frame.
module point_merge_sched
  import point_pkg::*;
(
  input  logic         CLK,
  input  logic         RESET,
  input  logic         VGA_HS,
  input  logic         VGA_VS,
  input  logic         BINARY_FLAG,
  input  logic [W-1:0] H_CNT,
  input  logic [W-1:0] V_CNT,
  output logic [W-1:0] o_POINTS_H_0,
  output logic [W-1:0] o_POINTS_H_1,
  output logic [W-1:0] o_POINTS_H_2,
  output logic [W-1:0] o_POINTS_H_3,
  output logic [W-1:0] o_POINTS_V_0,
  output logic [W-1:0] o_POINTS_V_1,
  output logic [W-1:0] o_POINTS_V_2,
  output logic [W-1:0] o_POINTS_V_3,
  output logic [2:0]   o_POINT_COUNT,
  output logic         o_RESULT_VALID,
  output logic         o_BUSY,
  output logic         o_OVERFLOW
);

  state_e state, state_next;
  logic hs_q, vs_q, hs_fall, vs_fall, in_idle;
  logic run_open, close_run, open_run, buf_full, push, drop;
  logic [W-1:0] start_h, last_h, last_v, mid_h;
  run_t run_mem [MAX_RUNS];
  run_t cur;
  logic [PTR_W:0] wr_cnt, n_runs, rd_ptr;
  logic merge_last;
  logic [MAX_PTS-1:0] active;
  logic [W-1:0] slot_h [MAX_PTS];
  logic [W-1:0] slot_v [MAX_PTS];
  logic [SUM_W-1:0] sum_h [MAX_PTS];
  logic [SUM_W-1:0] sum_v [MAX_PTS];
  logic [CNT_W-1:0] n_pix [MAX_PTS];
  logic ovf_frame, hit_found, free_found;
  logic [1:0] hit_idx, free_idx, div_slot;
  logic [2:0] pts, job, div_sel;
  logic [3:0] job_last;
  logic div_running, div_start, div_done;
  logic [SUM_W-1:0] div_dividend, div_quot;
  logic [CNT_W-1:0] div_divisor;
  logic [W-1:0] res [2*MAX_PTS];
  logic [W-1:0] out_h [MAX_PTS];
  logic [W-1:0] out_v [MAX_PTS];

  // A run also closes at end of line so runs never span two lines.
  assign hs_fall   = hs_q & ~VGA_HS;
  assign vs_fall   = vs_q & ~VGA_VS;
  assign in_idle   = (state == IDLE);
  assign close_run = in_idle & run_open & (~BINARY_FLAG | hs_fall);
  assign open_run  = in_idle & BINARY_FLAG & ~run_open & ~hs_fall;
  assign buf_full  = (wr_cnt == (PTR_W+1)'(MAX_RUNS));
  assign push      = close_run & ~buf_full;
  assign drop      = close_run & buf_full;
  assign mid_h     = W'(({1'b0, start_h} + {1'b0, last_h}) >> 1);
  assign cur       = run_mem[rd_ptr[PTR_W-1:0]];
  assign merge_last = (rd_ptr + (PTR_W+1)'(1) == n_runs);
  assign o_BUSY    = !in_idle;

  // Slots are allocated lowest-first and never freed mid-frame, so the
  // scans below pick the lowest matching / lowest free slot.
  always_comb begin
    logic [W:0] dh, dv, dh_abs;
    hit_found  = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    pts        = '0;
    for (int s = MAX_PTS-1; s >= 0; s--) begin
      dh     = {1'b0, cur.h} - {1'b0, slot_h[s]};
      dv     = {1'b0, cur.v} - {1'b0, slot_v[s]};
      dh_abs = dh[W] ? -dh : dh;
      if (active[s] && dh_abs <= (W+1)'(MERGE_DH) && !dv[W] && dv <= (W+1)'(MERGE_DV)) begin
        hit_found = 1'b1;
        hit_idx   = 2'(s);
      end
      if (!active[s]) begin
        free_found = 1'b1;
        free_idx   = 2'(s);
      end
      if (active[s]) pts = pts + 3'd1;
    end
  end

  assign job_last     = {pts, 1'b0} - 4'd1;
  assign div_sel      = (div_running && div_done) ? job + 3'd1 : job;
  assign div_slot     = div_sel[2:1];
  assign div_dividend = div_sel[0] ? sum_v[div_slot] : sum_h[div_slot];
  assign div_divisor  = n_pix[div_slot];

  always_comb begin
    state_next = state;
    div_start  = 1'b0;
    case (state)
      IDLE:    if (vs_fall) state_next = MERGE;
      MERGE:   if (n_runs == '0) state_next = PUBLISH;
               else if (merge_last) state_next = DIVIDE;
      DIVIDE: begin
        if (!div_running) div_start = 1'b1;
        else if (div_done) begin
          if ({1'b0, job} == job_last) state_next = PUBLISH;
          else div_start = 1'b1;
        end
      end
      PUBLISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      hs_q  <= 1'b0;
      vs_q  <= 1'b0;
    end else begin
      state <= state_next;
      hs_q  <= VGA_HS;
      vs_q  <= VGA_VS;
    end
  end

  // A run closing on the VS-fall cycle is pushed and counted in the frame.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      run_open <= 1'b0;
      start_h  <= '0;
      last_h   <= '0;
      last_v   <= '0;
      wr_cnt   <= '0;
      n_runs   <= '0;
    end else if (in_idle) begin
      if (open_run) begin
        run_open <= 1'b1;
        start_h  <= H_CNT;
        last_h   <= H_CNT;
        last_v   <= V_CNT;
      end else if (close_run) begin
        run_open <= 1'b0;
      end else if (run_open) begin
        last_h <= H_CNT;
        last_v <= V_CNT;
      end
      if (push) wr_cnt <= wr_cnt + (PTR_W+1)'(1);
      if (vs_fall) n_runs <= wr_cnt + (PTR_W+1)'(push);
    end else if (state == PUBLISH) begin
      run_open <= 1'b0;
      wr_cnt   <= '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) run_mem[wr_cnt[PTR_W-1:0]] <= '{h: mid_h, v: last_v};
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      active    <= '0;
      rd_ptr    <= '0;
      ovf_frame <= 1'b0;
      for (int s = 0; s < MAX_PTS; s++) begin
        slot_h[s] <= '0;
        slot_v[s] <= '0;
        sum_h[s]  <= '0;
        sum_v[s]  <= '0;
        n_pix[s]  <= '0;
      end
    end else begin
      if (drop) ovf_frame <= 1'b1;
      if (state == MERGE && n_runs != '0) begin
        rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        if (hit_found) begin
          slot_h[hit_idx] <= cur.h;
          slot_v[hit_idx] <= cur.v;
          sum_h[hit_idx]  <= sum_h[hit_idx] + SUM_W'(cur.h);
          sum_v[hit_idx]  <= sum_v[hit_idx] + SUM_W'(cur.v);
          n_pix[hit_idx]  <= n_pix[hit_idx] + CNT_W'(1);
        end else if (free_found) begin
          active[free_idx] <= 1'b1;
          slot_h[free_idx] <= cur.h;
          slot_v[free_idx] <= cur.v;
          sum_h[free_idx]  <= SUM_W'(cur.h);
          sum_v[free_idx]  <= SUM_W'(cur.v);
          n_pix[free_idx]  <= CNT_W'(1);
        end else begin
          ovf_frame <= 1'b1;
        end
      end else if (state == PUBLISH) begin
        active    <= '0;
        rd_ptr    <= '0;
        ovf_frame <= 1'b0;
      end
    end
  end

  // Jobs run slot 0 H, slot 0 V, slot 1 H, ... over active slots only.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      job         <= '0;
      div_running <= 1'b0;
      for (int j = 0; j < 2*MAX_PTS; j++) res[j] <= '0;
    end else if (state == DIVIDE) begin
      if (!div_running) begin
        div_running <= 1'b1;
      end else if (div_done) begin
        res[job] <= W'(div_quot);
        if ({1'b0, job} == job_last) begin
          div_running <= 1'b0;
          job         <= '0;
        end else begin
          job <= job + 3'd1;
        end
      end
    end
  end

  serial_divider u_div (
    .clk      (CLK),
    .rst      (RESET),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .done     (div_done),
    .quotient (div_quot)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      o_RESULT_VALID <= 1'b0;
      o_POINT_COUNT  <= '0;
      o_OVERFLOW     <= 1'b0;
      for (int s = 0; s < MAX_PTS; s++) begin
        out_h[s] <= '0;
        out_v[s] <= '0;
      end
    end else begin
      o_RESULT_VALID <= 1'b0;
      if (state == PUBLISH) begin
        o_RESULT_VALID <= 1'b1;
        o_POINT_COUNT  <= pts;
        o_OVERFLOW     <= ovf_frame;
        for (int s = 0; s < MAX_PTS; s++) begin
          out_h[s] <= active[s] ? res[2*s]   : '0;
          out_v[s] <= active[s] ? res[2*s+1] : '0;
        end
      end
    end
  end

  assign o_POINTS_H_0 = out_h[0];
  assign o_POINTS_H_1 = out_h[1];
  assign o_POINTS_H_2 = out_h[2];
  assign o_POINTS_H_3 = out_h[3];
  assign o_POINTS_V_0 = out_v[0];
  assign o_POINTS_V_1 = out_v[1];
  assign o_POINTS_V_2 = out_v[2];
  assign o_POINTS_V_3 = out_v[3];

endmodule
